// File: rtl/raw_scoreboard_pkg.sv
// Shared processor definitions for the RAW scoreboard: stall-cause encodings,
// default register-space/latency sizes and the latency clamp helper.
package raw_scoreboard_pkg;

  localparam int DEFAULT_NUM_REGS = 64;
  localparam int DEFAULT_MAX_LAT  = 8;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_RAW  = 2'd1,
    CAUSE_WAW  = 2'd2,
    CAUSE_PORT = 2'd3
  } stall_cause_e;

  // A zero latency still needs one edge to complete; anything beyond the
  // tracked window is pinned to the last slot.
  function automatic int clamp_lat(input int lat, input int max_lat);
    if (lat < 1) return 1;
    if (lat > max_lat) return max_lat;
    return lat;
  endfunction

endpackage

// File: rtl/raw_scoreboard_slot_queue.sv
// Completion shift queue: slot[0] is the register retiring this cycle, and a
// new write lands in slot[lat-1] after the whole queue has shifted down.
module sb_slot_queue #(
  parameter int MAX_LAT = 8,
  parameter int AW      = 6,
  parameter int LW      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ins_en,
  input  logic [LW-1:0]                 ins_lat,
  input  logic [AW-1:0]                 ins_rd,
  output logic [MAX_LAT-1:0]            slot_valid,
  output logic [MAX_LAT-1:0][AW-1:0]    slot_rd
);

  logic [MAX_LAT-1:0]         shift_valid;
  logic [MAX_LAT-1:0][AW-1:0] shift_rd;

  assign shift_valid = {1'b0, slot_valid[MAX_LAT-1:1]};
  assign shift_rd    = {AW'(0), slot_rd[MAX_LAT-1:1]};

  // Empty slots always carry rd=0 so an idle writeback port reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= '0;
      slot_rd    <= '0;
    end else begin
      for (int i = 0; i < MAX_LAT; i++) begin
        if (ins_en && (LW'(i + 1) == ins_lat)) begin
          slot_valid[i] <= 1'b1;
          slot_rd[i]    <= ins_rd;
        end else begin
          slot_valid[i] <= shift_valid[i];
          slot_rd[i]    <= shift_rd[i];
        end
      end
    end
  end

endmodule

// File: rtl/raw_scoreboard.sv
// Issue-stage RAW/WAW/writeback-port hazard checker built around a completion
// shift queue; refuses issue combinationally and reports why.
module raw_scoreboard
  import raw_scoreboard_pkg::*;
#(
  parameter int  NUM_REGS  = DEFAULT_NUM_REGS,
  parameter int  MAX_LAT   = DEFAULT_MAX_LAT,
  parameter bit  WB_BYPASS = 1'b1,
  localparam int AW        = $clog2(NUM_REGS),
  localparam int LW        = $clog2(MAX_LAT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rs1,
  input  logic [AW-1:0]       iss_rs2,
  input  logic                iss_rs1_used,
  input  logic                iss_rs2_used,
  input  logic [AW-1:0]       iss_rd,
  input  logic                iss_rd_we,
  input  logic [LW-1:0]       iss_lat,
  output logic                stall,
  output logic [1:0]          stall_cause,
  output logic                wb_valid,
  output logic [AW-1:0]       wb_rd,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [LW-1:0]       occupancy
);

  logic [MAX_LAT-1:0]         slot_valid;
  logic [MAX_LAT-1:0][AW-1:0] slot_rd;
  logic [LW-1:0]              eff_lat;
  logic                       rd_tracked;
  logic                       raw_hit;
  logic                       waw_hit;
  logic                       port_hit;
  logic                       ins_en;
  stall_cause_e               cause;

  assign eff_lat    = LW'(clamp_lat(int'(iss_lat), MAX_LAT));
  assign rd_tracked = iss_rd_we && (iss_rd != '0);

  // With bypass, the register leaving slot[0] is already forwardable.
  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (slot_valid[i] && !(WB_BYPASS && (i == 0))) busy_vec[slot_rd[i]] = 1'b1;
    end
  end

  // The slot that will shift into our target position must be free; a
  // full-window latency has nothing above it to collide with.
  always_comb begin
    port_hit = 1'b0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (LW'(i) == eff_lat) port_hit = slot_valid[i];
    end
  end

  assign raw_hit = (iss_rs1_used && busy_vec[iss_rs1]) ||
                   (iss_rs2_used && busy_vec[iss_rs2]);
  assign waw_hit = rd_tracked && busy_vec[iss_rd];

  always_comb begin
    cause = CAUSE_NONE;
    if (iss_valid) begin
      if (raw_hit)                    cause = CAUSE_RAW;
      else if (waw_hit)               cause = CAUSE_WAW;
      else if (rd_tracked && port_hit) cause = CAUSE_PORT;
    end
  end

  assign stall       = (cause != CAUSE_NONE);
  assign stall_cause = cause;
  assign ins_en      = iss_valid && !stall && !reset && rd_tracked;

  sb_slot_queue #(
    .MAX_LAT (MAX_LAT),
    .AW      (AW),
    .LW      (LW)
  ) u_slot_queue (
    .clk        (clk),
    .reset      (reset),
    .ins_en     (ins_en),
    .ins_lat    (eff_lat),
    .ins_rd     (iss_rd),
    .slot_valid (slot_valid),
    .slot_rd    (slot_rd)
  );

  assign wb_valid = slot_valid[0];
  assign wb_rd    = slot_rd[0];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < MAX_LAT; i++) occupancy = occupancy + LW'(slot_valid[i]);
  end

endmodule
